// File: rtl/lru_multiset_linked_list_pkg.sv
// Shared types and helpers for the multi-set LRU linked-list tracker.
// Operation encoding matches the access_op bus field.
package lru_pkg;

    typedef enum logic [1:0] {
        TOUCH     = 2'b00,
        DEMOTE    = 2'b01,
        RESET_SET = 2'b10,
        RSVD      = 2'b11
    } lru_op_e;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lru_multiset_linked_list_if.sv
// Access/query bus between the cache control logic (master) and the LRU tracker (slave).
interface lru_multiset_linked_list_if
    import lru_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 2
);
    localparam int PTR_WIDTH = idx_width(NUM_WAYS);
    localparam int SET_WIDTH = idx_width(NUM_SETS);

    logic                 access_valid;
    logic [SET_WIDTH-1:0] access_set;
    logic [PTR_WIDTH-1:0] access_way;
    lru_op_e              access_op;
    logic [SET_WIDTH-1:0] query_set;
    logic [PTR_WIDTH-1:0] lru_way;
    logic [PTR_WIDTH-1:0] mru_way;
    logic                 err;

    modport master (
        output access_valid, access_set, access_way, access_op, query_set,
        input  lru_way, mru_way, err
    );

    modport slave (
        input  access_valid, access_set, access_way, access_op, query_set,
        output lru_way, mru_way, err
    );

endinterface

// File: rtl/lru_multiset_linked_list_ll_set.sv
// One set's doubly linked recency list: head = MRU, tail = LRU.
// Links at the list ends are never read, so they may hold stale values.
module lru_ll_set
    import lru_pkg::*;
#(
    parameter int NUM_WAYS  = 4,
    parameter int PTR_WIDTH = idx_width(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 upd_en,
    input  lru_op_e              op,
    input  logic [PTR_WIDTH-1:0] way,
    output logic [PTR_WIDTH-1:0] head,
    output logic [PTR_WIDTH-1:0] tail
);

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    localparam ptr_t TAIL_RST = ptr_t'(NUM_WAYS - 1);

    ptr_t next_q [NUM_WAYS];
    ptr_t next_d [NUM_WAYS];
    ptr_t prev_q [NUM_WAYS];
    ptr_t prev_d [NUM_WAYS];
    ptr_t canon_next [NUM_WAYS];
    ptr_t canon_prev [NUM_WAYS];
    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    ptr_t p, n;

    // Canonical order 0..NUM_WAYS-1; the wrap-around end links are harmless.
    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_canon
            assign canon_next[gi] = ptr_t'((gi + 1) % NUM_WAYS);
            assign canon_prev[gi] = ptr_t'((gi + NUM_WAYS - 1) % NUM_WAYS);
        end
    endgenerate

    always_comb begin
        next_d = next_q;
        prev_d = prev_q;
        head_d = head_q;
        tail_d = tail_q;
        p      = prev_q[way];
        n      = next_q[way];
        if (upd_en) begin
            case (op)
                TOUCH: begin
                    if (way != head_q) begin
                        if (way == tail_q) tail_d = p;
                        else               prev_d[n] = p;
                        next_d[p]      = n;
                        next_d[way]    = head_q;
                        prev_d[head_q] = way;
                        head_d         = way;
                    end
                end
                DEMOTE: begin
                    if (way != tail_q) begin
                        if (way == head_q) head_d = n;
                        else               next_d[p] = n;
                        prev_d[n]      = p;
                        prev_d[way]    = tail_q;
                        next_d[tail_q] = way;
                        tail_d         = way;
                    end
                end
                RESET_SET: begin
                    next_d = canon_next;
                    prev_d = canon_prev;
                    head_d = '0;
                    tail_d = TAIL_RST;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            next_q <= canon_next;
            prev_q <= canon_prev;
            head_q <= '0;
            tail_q <= TAIL_RST;
        end else begin
            next_q <= next_d;
            prev_q <= prev_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign head = head_q;
    assign tail = tail_q;

endmodule

// File: rtl/lru_multiset_linked_list.sv
// Multi-set true-LRU tracker: decodes request legality, steers updates to one set,
// and reports the head/tail of the queried set.
module lru_multiset_linked_list
    import lru_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 2
) (
    input logic                       clk,
    input logic                       reset_n,
    lru_multiset_linked_list_if.slave bus
);

    localparam int PTR_WIDTH = idx_width(NUM_WAYS);
    localparam int SET_WIDTH = idx_width(NUM_SETS);

    logic [PTR_WIDTH-1:0] heads [NUM_SETS];
    logic [PTR_WIDTH-1:0] tails [NUM_SETS];
    logic                 set_ok, way_ok, query_ok, legal;
    logic                 err_q, err_d;

    // Zero-extended compares keep range checks meaningful for any parameter choice.
    always_comb begin
        set_ok   = {1'b0, bus.access_set} < (SET_WIDTH + 1)'(NUM_SETS);
        way_ok   = {1'b0, bus.access_way} < (PTR_WIDTH + 1)'(NUM_WAYS);
        query_ok = {1'b0, bus.query_set}  < (SET_WIDTH + 1)'(NUM_SETS);
        legal    = set_ok && ((bus.access_op == RESET_SET) ||
                              ((bus.access_op != RSVD) && way_ok));
        err_d    = bus.access_valid && !legal;
    end

    generate
        for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
            logic upd_en;
            assign upd_en = bus.access_valid && legal &&
                            (bus.access_set == SET_WIDTH'(gi));

            lru_ll_set #(
                .NUM_WAYS  (NUM_WAYS),
                .PTR_WIDTH (PTR_WIDTH)
            ) u_set (
                .clk     (clk),
                .reset_n (reset_n),
                .upd_en  (upd_en),
                .op      (bus.access_op),
                .way     (bus.access_way),
                .head    (heads[gi]),
                .tail    (tails[gi])
            );
        end
    endgenerate

    always_comb begin
        bus.lru_way = '0;
        bus.mru_way = '0;
        if (query_ok) begin
            bus.lru_way = tails[bus.query_set];
            bus.mru_way = heads[bus.query_set];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign bus.err = err_q;

endmodule

// File: tb/tb_lru_multiset_linked_list.sv
// Directed bench for the multi-set LRU tracker: 4-way/2-set, 3-way/3-set and 1-way/2-set copies.
module tb_lru_multiset_linked_list;
    import lru_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    lru_multiset_linked_list_if #(.NUM_WAYS(4), .NUM_SETS(2)) if4 ();
    lru_multiset_linked_list_if #(.NUM_WAYS(3), .NUM_SETS(3)) if3 ();
    lru_multiset_linked_list_if #(.NUM_WAYS(1), .NUM_SETS(2)) if1 ();

    lru_multiset_linked_list #(.NUM_WAYS(4), .NUM_SETS(2)) u4 (.clk(clk), .reset_n(reset_n), .bus(if4));
    lru_multiset_linked_list #(.NUM_WAYS(3), .NUM_SETS(3)) u3 (.clk(clk), .reset_n(reset_n), .bus(if3));
    lru_multiset_linked_list #(.NUM_WAYS(1), .NUM_SETS(2)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv4(input logic v, input int s, input int w, input lru_op_e op);
        if4.access_valid = v;
        if4.access_set   = 1'(s);
        if4.access_way   = 2'(w);
        if4.access_op    = op;
        if (v) $display("txn u4 op=%s set=%0d way=%0d", op.name(), s, w);
    endtask

    task automatic drv3(input logic v, input int s, input int w, input lru_op_e op);
        if3.access_valid = v;
        if3.access_set   = 2'(s);
        if3.access_way   = 2'(w);
        if3.access_op    = op;
        if (v) $display("txn u3 op=%s set=%0d way=%0d", op.name(), s, w);
    endtask

    task automatic drv1(input logic v, input int s, input int w, input lru_op_e op);
        if1.access_valid = v;
        if1.access_set   = 1'(s);
        if1.access_way   = 1'(w);
        if1.access_op    = op;
        if (v) $display("txn u1 op=%s set=%0d way=%0d", op.name(), s, w);
    endtask

    task automatic idle_all();
        drv4(1'b0, 0, 0, TOUCH);
        drv3(1'b0, 0, 0, TOUCH);
        drv1(1'b0, 0, 0, TOUCH);
    endtask

    task automatic peek4(input int s, output logic [31:0] l, output logic [31:0] m);
        if4.query_set = 1'(s);
        #1;
        l = 32'(if4.lru_way);
        m = 32'(if4.mru_way);
    endtask

    task automatic peek3(input int s, output logic [31:0] l, output logic [31:0] m);
        if3.query_set = 2'(s);
        #1;
        l = 32'(if3.lru_way);
        m = 32'(if3.mru_way);
    endtask

    task automatic peek1(input int s, output logic [31:0] l, output logic [31:0] m);
        if1.query_set = 1'(s);
        #1;
        l = 32'(if1.lru_way);
        m = 32'(if1.mru_way);
    endtask

    task automatic do_reset();
        idle_all();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] l, m;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            peek4(s, l, m);
            vectors++;
            if (l !== 3 || m !== 0) begin
                miscompares++;
                $display("FAIL reset_u4_set%0d: lru=%0d mru=%0d required lru=3 mru=0", s, l, m);
            end
        end
        for (int s = 0; s < 3; s++) begin
            peek3(s, l, m);
            vectors++;
            if (l !== 2 || m !== 0) begin
                miscompares++;
                $display("FAIL reset_u3_set%0d: lru=%0d mru=%0d required lru=2 mru=0", s, l, m);
            end
        end
        peek1(0, l, m);
        vectors++;
        if (l !== 0 || m !== 0) begin
            miscompares++;
            $display("FAIL reset_u1: lru=%0d mru=%0d required lru=0 mru=0", l, m);
        end
        vectors++;
        if (if4.err !== 1'b0 || if3.err !== 1'b0 || if1.err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: err u4=%b u3=%b u1=%b required 0", if4.err, if3.err, if1.err);
        end
    endtask

    task automatic test_touch();
        logic [31:0] l, m;
        drv4(1'b1, 0, 3, TOUCH);
        peek4(0, l, m);
        vectors++;
        if (l !== 3 || m !== 0) begin
            miscompares++;
            $display("FAIL touch_no_bypass: lru=%0d mru=%0d required lru=3 mru=0", l, m);
        end
        tick();
        drv4(1'b0, 0, 0, TOUCH);
        peek4(0, l, m);
        vectors++;
        if (l !== 2 || m !== 3) begin
            miscompares++;
            $display("FAIL touch_set0: lru=%0d mru=%0d required lru=2 mru=3", l, m);
        end
        peek4(1, l, m);
        vectors++;
        if (l !== 3 || m !== 0) begin
            miscompares++;
            $display("FAIL touch_set1_untouched: lru=%0d mru=%0d required lru=3 mru=0", l, m);
        end
        vectors++;
        if (if4.err !== 1'b0) begin
            miscompares++;
            $display("FAIL touch_err: err=%b required 0", if4.err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] l, m;
        int ways  [5] = '{3, 2, 1, 0, 2};
        int exp_l [5] = '{2, 1, 0, 3, 3};
        int exp_m [5] = '{3, 2, 1, 0, 2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv4(1'b1, 0, ways[i], TOUCH);
            tick();
            if (i == 4) drv4(1'b0, 0, 0, TOUCH);
            peek4(0, l, m);
            vectors++;
            if (l !== 32'(exp_l[i]) || m !== 32'(exp_m[i])) begin
                miscompares++;
                $display("FAIL b2b_touch%0d: lru=%0d mru=%0d required lru=%0d mru=%0d",
                         i, l, m, exp_l[i], exp_m[i]);
            end
        end
    endtask

    task automatic test_demote();
        logic [31:0] l, m;
        lru_op_e ops [7] = '{DEMOTE, DEMOTE, DEMOTE, TOUCH, DEMOTE, DEMOTE, DEMOTE};
        int ways  [7] = '{2, 2, 0, 2, 1, 2, 3};
        int exp_l [7] = '{2, 2, 0, 0, 1, 2, 3};
        int exp_m [7] = '{0, 0, 1, 2, 2, 3, 0};
        // Starts from set0 order 2,0,1,3 left by test_back_to_back.
        for (int i = 0; i < 7; i++) begin
            drv4(1'b1, 0, ways[i], ops[i]);
            tick();
            drv4(1'b0, 0, 0, TOUCH);
            peek4(0, l, m);
            vectors++;
            if (l !== 32'(exp_l[i]) || m !== 32'(exp_m[i])) begin
                miscompares++;
                $display("FAIL demote_seq%0d: lru=%0d mru=%0d required lru=%0d mru=%0d",
                         i, l, m, exp_l[i], exp_m[i]);
            end
        end
        drv4(1'b1, 1, 2, TOUCH);
        tick();
        drv4(1'b1, 0, 1, DEMOTE);
        tick();
        drv4(1'b0, 0, 0, TOUCH);
        peek4(0, l, m);
        vectors++;
        if (l !== 1 || m !== 0) begin
            miscompares++;
            $display("FAIL demote_mid_set0: lru=%0d mru=%0d required lru=1 mru=0", l, m);
        end
        drv4(1'b1, 0, 3, RESET_SET);
        tick();
        drv4(1'b0, 0, 0, TOUCH);
        peek4(0, l, m);
        vectors++;
        if (l !== 3 || m !== 0) begin
            miscompares++;
            $display("FAIL reset_set0: lru=%0d mru=%0d required lru=3 mru=0", l, m);
        end
        peek4(1, l, m);
        vectors++;
        if (l !== 3 || m !== 2) begin
            miscompares++;
            $display("FAIL reset_set0_keeps_set1: lru=%0d mru=%0d required lru=3 mru=2", l, m);
        end
        vectors++;
        if (if4.err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_set_err: err=%b required 0", if4.err);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] l, m;
        // u4: set0 canonical, set1 order 2,0,1,3.
        drv4(1'b1, 1, 1, RSVD);
        tick();
        drv4(1'b0, 0, 0, TOUCH);
        vectors++;
        if (if4.err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_rsvd_err: err=%b required 1", if4.err);
        end
        peek4(1, l, m);
        vectors++;
        if (l !== 3 || m !== 2) begin
            miscompares++;
            $display("FAIL illegal_rsvd_state: lru=%0d mru=%0d required lru=3 mru=2", l, m);
        end
        tick();
        vectors++;
        if (if4.err !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_err_pulse: err=%b required 0", if4.err);
        end
        // u3: 3 ways, 3 sets, all canonical.
        drv3(1'b1, 1, 2, TOUCH);
        tick();
        drv3(1'b1, 1, 3, TOUCH);
        peek3(1, l, m);
        vectors++;
        if (l !== 1 || m !== 2 || if3.err !== 1'b0) begin
            miscompares++;
            $display("FAIL u3_touch: lru=%0d mru=%0d err=%b required lru=1 mru=2 err=0", l, m, if3.err);
        end
        tick();
        drv3(1'b1, 3, 0, DEMOTE);
        peek3(1, l, m);
        vectors++;
        if (l !== 1 || m !== 2 || if3.err !== 1'b1) begin
            miscompares++;
            $display("FAIL u3_bad_way: lru=%0d mru=%0d err=%b required lru=1 mru=2 err=1", l, m, if3.err);
        end
        tick();
        drv3(1'b1, 1, 3, RESET_SET);
        vectors++;
        if (if3.err !== 1'b1) begin
            miscompares++;
            $display("FAIL u3_bad_set_err: err=%b required 1", if3.err);
        end
        for (int s = 0; s < 3; s += 2) begin
            peek3(s, l, m);
            vectors++;
            if (l !== 2 || m !== 0) begin
                miscompares++;
                $display("FAIL u3_bad_set_state%0d: lru=%0d mru=%0d required lru=2 mru=0", s, l, m);
            end
        end
        peek3(3, l, m);
        vectors++;
        if (l !== 0 || m !== 0) begin
            miscompares++;
            $display("FAIL u3_query_oor: lru=%0d mru=%0d required lru=0 mru=0", l, m);
        end
        tick();
        drv3(1'b1, 2, 0, DEMOTE);
        peek3(1, l, m);
        vectors++;
        if (l !== 2 || m !== 0 || if3.err !== 1'b0) begin
            miscompares++;
            $display("FAIL u3_reset_set: lru=%0d mru=%0d err=%b required lru=2 mru=0 err=0", l, m, if3.err);
        end
        tick();
        drv3(1'b0, 0, 0, TOUCH);
        peek3(2, l, m);
        vectors++;
        if (l !== 0 || m !== 1) begin
            miscompares++;
            $display("FAIL u3_demote_head: lru=%0d mru=%0d required lru=0 mru=1", l, m);
        end
    endtask

    task automatic test_reset_priority();
        logic [31:0] l, m;
        drv4(1'b1, 1, 3, TOUCH);
        drv3(1'b1, 3, 0, TOUCH);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        idle_all();
        peek4(1, l, m);
        vectors++;
        if (l !== 3 || m !== 0 || if4.err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_prio_u4: lru=%0d mru=%0d err=%b required lru=3 mru=0 err=0", l, m, if4.err);
        end
        peek3(2, l, m);
        vectors++;
        if (l !== 2 || m !== 0 || if3.err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_prio_u3: lru=%0d mru=%0d err=%b required lru=2 mru=0 err=0", l, m, if3.err);
        end
    endtask

    task automatic test_one_way();
        logic [31:0] l, m;
        lru_op_e ops [4] = '{TOUCH, DEMOTE, TOUCH, DEMOTE};
        int sets [4] = '{0, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            drv1(1'b1, sets[i], 0, ops[i]);
            tick();
            drv1(1'b0, 0, 0, TOUCH);
            peek1(sets[i], l, m);
            vectors++;
            if (l !== 0 || m !== 0 || if1.err !== 1'b0) begin
                miscompares++;
                $display("FAIL one_way%0d: lru=%0d mru=%0d err=%b required lru=0 mru=0 err=0",
                         i, l, m, if1.err);
            end
        end
        drv1(1'b1, 0, 1, TOUCH);
        tick();
        drv1(1'b0, 0, 0, TOUCH);
        peek1(0, l, m);
        vectors++;
        if (l !== 0 || m !== 0 || if1.err !== 1'b1) begin
            miscompares++;
            $display("FAIL one_way_bad: lru=%0d mru=%0d err=%b required lru=0 mru=0 err=1", l, m, if1.err);
        end
    endtask

    initial begin
        if4.query_set = '0;
        if3.query_set = '0;
        if1.query_set = '0;
        test_reset();
        test_touch();
        test_back_to_back();
        test_demote();
        test_illegal();
        test_reset_priority();
        test_one_way();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
